// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for a five-stage forwarding pipeline: EX operand forwarding,
// load-use bubbles, data-memory wait freezing with timeout, and EX redirect flushes.
// Optional build macro HAZARD_PERF_EN adds 32-bit performance counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] rs1_addr_D,
  input  logic [4:0] rs2_addr_D,
  input  logic       rs1_used_D,
  input  logic       rs2_used_D,
  input  logic [4:0] rs1_addr_E,
  input  logic [4:0] rs2_addr_E,
  input  logic [4:0] rd_addr_E,
  input  logic [4:0] rd_addr_M,
  input  logic [4:0] rd_addr_W,
  input  logic       rd_wren_E,
  input  logic       rd_wren_M,
  input  logic       rd_wren_W,
  input  logic [1:0] wb_sel_E,
  input  logic       pc_sel_E,
  input  logic       mem_req_M,
  input  logic       mem_ack_M,
  output logic       o_stall_F,
  output logic       o_stall_D,
  output logic       o_stall_E,
  output logic       o_stall_M,
  output logic       o_flush_D,
  output logic       o_flush_E,
  output logic       o_flush_W,
  output logic [1:0] o_fwd_a_sel,
  output logic [1:0] o_fwd_b_sel,
  output logic [1:0] o_state,
  output logic       o_mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] o_ldstall_cnt,
  output logic [31:0] o_mwait_cnt,
  output logic [31:0] o_redirect_cnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(MEM_TIMEOUT);

  localparam logic [1:0] S_RUN     = 2'b00;
  localparam logic [1:0] S_LDSTALL = 2'b01;
  localparam logic [1:0] S_MWAIT   = 2'b10;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] wait_cnt;

  logic in_mwait;
  logic in_ldstall;
  logic memwait;
  logic timeout_hit;
  logic hold;
  logic load_use;
  logic redirect_act;
  logic load_use_act;

  // M result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] rd_m, input logic wren_m,
                                         input logic [4:0] rd_w, input logic wren_w);
    if (wren_m && rd_m != 5'd0 && rd_m == src)      return 2'b01;
    else if (wren_w && rd_w != 5'd0 && rd_w == src) return 2'b10;
    else                                            return 2'b00;
  endfunction

  assign o_fwd_a_sel = fwd_sel(rs1_addr_E, rd_addr_M, rd_wren_M, rd_addr_W, rd_wren_W);
  assign o_fwd_b_sel = fwd_sel(rs2_addr_E, rd_addr_M, rd_wren_M, rd_addr_W, rd_wren_W);

  assign in_mwait   = (state == S_MWAIT);
  assign in_ldstall = (state == S_LDSTALL);
  assign memwait    = mem_req_M & ~mem_ack_M;

  assign load_use = (wb_sel_E == 2'b01) && rd_wren_E && (rd_addr_E != 5'd0) &&
                    ((rs1_used_D && rs1_addr_D == rd_addr_E) ||
                     (rs2_used_D && rs2_addr_D == rd_addr_E));

  // The timeout cycle releases the pipeline outright; the stuck access is abandoned.
  assign timeout_hit  = in_mwait & ~mem_ack_M & (wait_cnt == CNT_LIMIT);
  assign hold         = ~timeout_hit & (memwait | (in_mwait & ~mem_ack_M));
  assign redirect_act = ~hold & ~timeout_hit & pc_sel_E;
  assign load_use_act = ~hold & ~timeout_hit & ~pc_sel_E & ~in_ldstall & load_use;

  assign o_stall_F = hold | load_use_act;
  assign o_stall_D = hold | load_use_act;
  assign o_stall_E = hold;
  assign o_stall_M = hold;
  assign o_flush_D = redirect_act;
  assign o_flush_E = redirect_act | load_use_act;
  assign o_flush_W = hold;
  assign o_state   = state;

  // NOTE: always_comb gives every output a default first so no path can infer a latch.
  always_comb begin
    state_nxt = S_RUN;
    if (hold)              state_nxt = S_MWAIT;
    else if (load_use_act) state_nxt = S_LDSTALL;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_RUN;
      wait_cnt      <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hold) begin
        if (!in_mwait)                wait_cnt <= '0;
        else if (wait_cnt != CNT_LIMIT) wait_cnt <= wait_cnt + CW'(1);
      end
      if (timeout_hit) o_mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ldstall_cnt  <= '0;
      o_mwait_cnt    <= '0;
      o_redirect_cnt <= '0;
    end else begin
      if (load_use_act) o_ldstall_cnt  <= o_ldstall_cnt + 32'd1;
      if (hold)         o_mwait_cnt    <= o_mwait_cnt + 32'd1;
      if (redirect_act) o_redirect_cnt <= o_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
  logic       rs1_used_D, rs2_used_D;
  logic [4:0] rd_addr_E, rd_addr_M, rd_addr_W;
  logic       rd_wren_E, rd_wren_M, rd_wren_W;
  logic [1:0] wb_sel_E;
  logic       pc_sel_E, mem_req_M, mem_ack_M;
  logic       o_stall_F, o_stall_D, o_stall_E, o_stall_M;
  logic       o_flush_D, o_flush_E, o_flush_W;
  logic [1:0] o_fwd_a_sel, o_fwd_b_sel, o_state;
  logic       o_mem_timeout;

  int checks = 0;
  int failures = 0;

  // Model state for the randomized test.
  bit m_waiting;
  int m_waited;
  bit m_bubble;
  bit m_to;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
    .rd_addr_E(rd_addr_E), .rd_addr_M(rd_addr_M), .rd_addr_W(rd_addr_W),
    .rd_wren_E(rd_wren_E), .rd_wren_M(rd_wren_M), .rd_wren_W(rd_wren_W),
    .wb_sel_E(wb_sel_E), .pc_sel_E(pc_sel_E),
    .mem_req_M(mem_req_M), .mem_ack_M(mem_ack_M),
    .o_stall_F(o_stall_F), .o_stall_D(o_stall_D), .o_stall_E(o_stall_E), .o_stall_M(o_stall_M),
    .o_flush_D(o_flush_D), .o_flush_E(o_flush_E), .o_flush_W(o_flush_W),
    .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel),
    .o_state(o_state), .o_mem_timeout(o_mem_timeout)
  );

  always #5 i_clk = ~i_clk;

  logic [6:0] ctrl;
  assign ctrl = {o_stall_F, o_stall_D, o_stall_E, o_stall_M, o_flush_D, o_flush_E, o_flush_W};

  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_FREEZE = 7'b1111001;
  localparam logic [6:0] C_LDUSE  = 7'b1100010;
  localparam logic [6:0] C_REDIR  = 7'b0000110;

  task automatic idle();
    rs1_addr_D = 0; rs2_addr_D = 0; rs1_used_D = 0; rs2_used_D = 0;
    rs1_addr_E = 0; rs2_addr_E = 0;
    rd_addr_E = 0; rd_addr_M = 0; rd_addr_W = 0;
    rd_wren_E = 0; rd_wren_M = 0; rd_wren_W = 0;
    wb_sel_E = 0; pc_sel_E = 0; mem_req_M = 0; mem_ack_M = 0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    i_rst_n = 1'b0;
    #3;
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    i_rst_n = 1'b0;
    #3;
    checks++;
    if ({ctrl, o_fwd_a_sel, o_fwd_b_sel, o_state, o_mem_timeout} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ctrl=%b fa=%b fb=%b st=%b to=%b, want all zero",
               ctrl, o_fwd_a_sel, o_fwd_b_sel, o_state, o_mem_timeout);
    end
    i_rst_n = 1'b1;
    tick();
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID.
  task automatic test_load_use();
    do_reset();
    wb_sel_E = 2'b01; rd_wren_E = 1; rd_addr_E = 5;
    rs1_addr_D = 5; rs1_used_D = 1; rs2_addr_D = 1; rs2_used_D = 1;
    #1;
    checks++;
    if (ctrl !== C_LDUSE) begin
      failures++; $display("FAIL lu_stall: ctrl=%b want %b", ctrl, C_LDUSE);
    end
    tick();
    idle();
    rd_addr_M = 5; rd_wren_M = 1; rs1_addr_D = 5; rs1_used_D = 1;
    #1;
    checks++;
    if (o_state !== 2'b01 || ctrl !== C_NONE) begin
      failures++; $display("FAIL lu_bubble: state=%b ctrl=%b want 01/%b", o_state, ctrl, C_NONE);
    end
    tick();
    idle();
    rs1_addr_E = 5; rs2_addr_E = 1; rd_addr_W = 5; rd_wren_W = 1;
    #1;
    checks++;
    if (o_fwd_a_sel !== 2'b10 || o_fwd_b_sel !== 2'b00 || o_state !== 2'b00) begin
      failures++; $display("FAIL lu_fwd: fa=%b fb=%b st=%b want 10/00/00", o_fwd_a_sel, o_fwd_b_sel, o_state);
    end
    // Load-use through rs2; then the same with x0 as destination, which is never a hazard.
    idle();
    wb_sel_E = 2'b01; rd_wren_E = 1; rd_addr_E = 7; rs2_addr_D = 7; rs2_used_D = 1;
    #1;
    checks++;
    if (ctrl !== C_LDUSE) begin
      failures++; $display("FAIL lu_rs2: ctrl=%b want %b", ctrl, C_LDUSE);
    end
    rd_addr_E = 0; rs2_addr_D = 0;
    #1;
    checks++;
    if (ctrl !== C_NONE) begin
      failures++; $display("FAIL lu_x0: ctrl=%b want %b", ctrl, C_NONE);
    end
    rd_addr_E = 7; rs2_addr_D = 7; rs2_used_D = 0;
    #1;
    checks++;
    if (ctrl !== C_NONE) begin
      failures++; $display("FAIL lu_unused: ctrl=%b want %b", ctrl, C_NONE);
    end
    idle();
    tick();
  endtask

  task automatic test_forwarding();
    idle();
    rd_addr_M = 3; rd_wren_M = 1; rd_addr_W = 3; rd_wren_W = 1; rs2_addr_E = 3; rs1_addr_E = 4;
    #1;
    checks++;
    if (o_fwd_b_sel !== 2'b01 || o_fwd_a_sel !== 2'b00) begin
      failures++; $display("FAIL fwd_m_prio: fa=%b fb=%b want 00/01", o_fwd_a_sel, o_fwd_b_sel);
    end
    rd_wren_M = 0;
    #1;
    checks++;
    if (o_fwd_b_sel !== 2'b10) begin
      failures++; $display("FAIL fwd_w: fb=%b want 10", o_fwd_b_sel);
    end
    rd_wren_M = 1; rd_addr_M = 0; rd_addr_W = 0; rs2_addr_E = 0; rs1_addr_E = 0;
    #1;
    checks++;
    if (o_fwd_a_sel !== 2'b00 || o_fwd_b_sel !== 2'b00) begin
      failures++; $display("FAIL fwd_x0: fa=%b fb=%b want 00/00", o_fwd_a_sel, o_fwd_b_sel);
    end
    idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req_M = 1; mem_ack_M = 1;
    #1;
    checks++;
    if (ctrl !== C_NONE || o_state !== 2'b00) begin
      failures++; $display("FAIL mem_same_cycle_ack: ctrl=%b st=%b want %b/00", ctrl, o_state, C_NONE);
    end
    tick();
    mem_ack_M = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ctrl !== C_FREEZE || o_state !== ((i == 0) ? 2'b00 : 2'b10)) begin
        failures++; $display("FAIL mem_wait_%0d: ctrl=%b st=%b want %b", i, ctrl, o_state, C_FREEZE);
      end
      tick();
    end
    mem_ack_M = 1;
    #1;
    checks++;
    if (ctrl !== C_NONE || o_state !== 2'b10) begin
      failures++; $display("FAIL mem_ack: ctrl=%b st=%b want %b/10", ctrl, o_state, C_NONE);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o_state !== 2'b00 || o_mem_timeout !== 1'b0) begin
      failures++; $display("FAIL mem_after: st=%b to=%b want 00/0", o_state, o_mem_timeout);
    end
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    wb_sel_E = 2'b01; rd_wren_E = 1; rd_addr_E = 9; rs1_addr_D = 9; rs1_used_D = 1; pc_sel_E = 1;
    #1;
    checks++;
    if (ctrl !== C_REDIR) begin
      failures++; $display("FAIL redir_lu: ctrl=%b want %b", ctrl, C_REDIR);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o_state !== 2'b00) begin
      failures++; $display("FAIL redir_state: st=%b want 00", o_state);
    end
  endtask

  // Freezes for TO+1 cycles (RUN entry plus TO counted MWAIT cycles), then releases.
  task automatic test_timeout();
    do_reset();
    mem_req_M = 1;
    for (int i = 0; i <= TO + 1; i++) begin
      #1;
      checks++;
      if (ctrl !== ((i <= TO) ? C_FREEZE : C_NONE)) begin
        failures++; $display("FAIL timeout_cyc%0d: ctrl=%b want %b", i, ctrl,
                             (i <= TO) ? C_FREEZE : C_NONE);
      end
      tick();
    end
    mem_req_M = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_mem_timeout !== 1'b1 || o_state !== 2'b00) begin
        failures++; $display("FAIL timeout_sticky%0d: to=%b st=%b want 1/00", i, o_mem_timeout, o_state);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_req_M = 1;
    for (int i = 0; i < 3; i++) tick();
    #1;
    checks++;
    if (o_state !== 2'b10 || ctrl !== C_FREEZE) begin
      failures++; $display("FAIL rst_pre: st=%b ctrl=%b want 10/%b", o_state, ctrl, C_FREEZE);
    end
    #1;
    i_rst_n = 1'b0;
    idle();
    #1;
    checks++;
    if ({ctrl, o_state, o_mem_timeout} !== 10'd0) begin
      failures++; $display("FAIL rst_mid_wait: ctrl=%b st=%b to=%b want zero", ctrl, o_state, o_mem_timeout);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    mem_req_M = 1;
    for (int i = 0; i <= TO + 1; i++) begin
      #1;
      checks++;
      if (ctrl !== ((i <= TO) ? C_FREEZE : C_NONE)) begin
        failures++; $display("FAIL rst_cnt_cyc%0d: ctrl=%b", i, ctrl);
      end
      tick();
    end
    idle();
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (rd_wren_M && rd_addr_M != 0 && rd_addr_M == src) return 2'b01;
    if (rd_wren_W && rd_addr_W != 0 && rd_addr_W == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_random();
    bit lu, to_now, freeze;
    logic [6:0] e_ctrl;
    logic [1:0] e_state;
    logic [13:0] got, exp;
    do_reset();
    m_waiting = 0; m_waited = 0; m_bubble = 0; m_to = 0;
    for (int n = 0; n < 600; n++) begin
      rs1_addr_D = 5'($urandom_range(0, 3)); rs2_addr_D = 5'($urandom_range(0, 3));
      rs1_used_D = 1'($urandom); rs2_used_D = 1'($urandom);
      rs1_addr_E = 5'($urandom_range(0, 3)); rs2_addr_E = 5'($urandom_range(0, 3));
      rd_addr_E = 5'($urandom_range(0, 3)); rd_addr_M = 5'($urandom_range(0, 3));
      rd_addr_W = 5'($urandom_range(0, 3));
      rd_wren_E = 1'($urandom); rd_wren_M = 1'($urandom); rd_wren_W = 1'($urandom);
      wb_sel_E = 2'($urandom);
      pc_sel_E = ($urandom_range(0, 5) == 0);
      mem_req_M = ($urandom_range(0, 3) == 0);
      mem_ack_M = 1'($urandom);
      #1;
      lu = !m_bubble && wb_sel_E == 2'b01 && rd_wren_E && rd_addr_E != 0 &&
           ((rs1_used_D && rs1_addr_D == rd_addr_E) || (rs2_used_D && rs2_addr_D == rd_addr_E));
      to_now = m_waiting && !mem_ack_M && m_waited == TO;
      freeze = !to_now && ((mem_req_M && !mem_ack_M) || (m_waiting && !mem_ack_M));
      e_state = m_waiting ? 2'b10 : (m_bubble ? 2'b01 : 2'b00);
      if (to_now)        e_ctrl = C_NONE;
      else if (freeze)   e_ctrl = C_FREEZE;
      else if (pc_sel_E) e_ctrl = C_REDIR;
      else if (lu)       e_ctrl = C_LDUSE;
      else               e_ctrl = C_NONE;
      exp = {e_ctrl, ref_fwd(rs1_addr_E), ref_fwd(rs2_addr_E), e_state, m_to};
      got = {ctrl, o_fwd_a_sel, o_fwd_b_sel, o_state, o_mem_timeout};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_cyc%0d: got ctrl/fa/fb/st/to=%b want %b", n, got, exp);
      end
      if (to_now) begin
        m_to = 1; m_waiting = 0; m_bubble = 0;
      end else if (freeze) begin
        m_waited = m_waiting ? ((m_waited < TO) ? m_waited + 1 : TO) : 0;
        m_waiting = 1; m_bubble = 0;
      end else begin
        m_waiting = 0;
        m_bubble = !pc_sel_E && lu;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    i_rst_n = 1'b1;
    #2;
    test_reset();
    test_load_use();
    test_forwarding();
    test_mem_wait();
    test_redirect_load_use();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
